// File: rtl/control_sequencer.sv
// ============================================================================
// control_sequencer : fetch/execute sequencer holding IR, step and status
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
  parameter int MAX_STEPS = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        run,
  input  logic [31:0] instr_in,
  input  logic        instr_valid,
  input  logic [4:0]  status_in,
  input  logic [32:0] cw_in,
  output logic        fetch_req,
  output logic [31:0] ir_q,
  output logic [1:0]  state_q,
  output logic [4:0]  status_q,
  output logic [32:0] cw_out,
  output logic        busy,
  output logic        seq_fault
);

  localparam logic [1:0] C_LAST_STEP = 2'(MAX_STEPS - 1);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    EXEC  = 1'b1
  } phase_e;

  phase_e      phase_q, phase_d;
  logic [31:0] ir_d;
  logic [1:0]  state_d;
  logic [1:0]  step_q, step_d;
  logic [4:0]  status_d;
  logic        fault_d;
  logic        w_accept;

  assign w_accept = run & instr_valid;

  always_comb begin
    phase_d   = phase_q;
    ir_d      = ir_q;
    state_d   = state_q;
    step_d    = step_q;
    status_d  = status_q;
    fault_d   = 1'b0;
    fetch_req = 1'b0;
    busy      = 1'b0;
    cw_out    = '0;

    case (phase_q)
      FETCH: begin
        fetch_req = run;
        if (w_accept) begin
          cw_out[5:4] = 2'b01;
          ir_d        = instr_in;
          state_d     = 2'd0;
          step_d      = 2'd0;
          phase_d     = EXEC;
        end
      end
      EXEC: begin
        busy   = 1'b1;
        cw_out = cw_in;
        if (cw_in[2]) status_d = status_in;
        // Limit check precedes the increment, so the step counter never wraps.
        if (cw_in[1:0] == 2'b00) begin
          phase_d = FETCH;
        end else if (step_q == C_LAST_STEP) begin
          phase_d = FETCH;
          fault_d = 1'b1;
        end else begin
          state_d = cw_in[1:0];
          step_d  = step_q + 2'd1;
        end
      end
      default: phase_d = FETCH;
    endcase

    // No datapath write may escape during a reset cycle.
    if (!reset_n) begin
      fetch_req = 1'b0;
      busy      = 1'b0;
      cw_out    = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      phase_q   <= FETCH;
      ir_q      <= '0;
      state_q   <= '0;
      step_q    <= '0;
      status_q  <= '0;
      seq_fault <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ir_q      <= ir_d;
      state_q   <= state_d;
      step_q    <= step_d;
      status_q  <= status_d;
      seq_fault <= fault_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// tb_control_sequencer : directed + random check against a behavioural model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

  localparam int MAX_STEPS = 4;

  logic        clock = 1'b0;
  logic        reset_n, run, instr_valid;
  logic [31:0] instr_in;
  logic [4:0]  status_in;
  logic [32:0] cw_in;
  logic        fetch_req, busy, seq_fault;
  logic [31:0] ir_q;
  logic [1:0]  state_q;
  logic [4:0]  status_q;
  logic [32:0] cw_out;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: an instruction is "in flight" for a number of execute
  // cycles; it ends on NS=0 or once MAX_STEPS cycles have been spent.
  bit          m_init = 0;
  bit          m_inflight;
  int          m_cycles;
  logic [31:0] m_ir;
  logic [1:0]  m_step;
  logic [4:0]  m_status;
  bit          m_fault;

  always #5 clock = ~clock;

  control_sequencer #(.MAX_STEPS(MAX_STEPS)) dut (
    .clock(clock), .reset_n(reset_n), .run(run), .instr_in(instr_in),
    .instr_valid(instr_valid), .status_in(status_in), .cw_in(cw_in),
    .fetch_req(fetch_req), .ir_q(ir_q), .state_q(state_q),
    .status_q(status_q), .cw_out(cw_out), .busy(busy), .seq_fault(seq_fault)
  );

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic apply(input bit rstn, input bit r, input bit v,
                       input logic [31:0] ins, input logic [4:0] st,
                       input logic [32:0] cw);
    logic [32:0] exp_cw;
    @(negedge clock);
    reset_n = rstn; run = r; instr_valid = v;
    instr_in = ins; status_in = st; cw_in = cw;
    #1;
    if (!rstn)            exp_cw = '0;
    else if (m_inflight)  exp_cw = cw;
    else if (r && v)      exp_cw = 33'h0_0000_0010;
    else                  exp_cw = '0;
    chk("cw_out", cw_out, exp_cw);
    chk("fetch_req", 33'(fetch_req), 33'(rstn && !m_inflight && r));
    chk("busy", 33'(busy), 33'(rstn && m_inflight));
    if (m_init) begin
      chk("ir_q", 33'(ir_q), 33'(m_ir));
      chk("state_q", 33'(state_q), 33'(m_step));
      chk("status_q", 33'(status_q), 33'(m_status));
      chk("seq_fault", 33'(seq_fault), 33'(m_fault));
    end
    @(posedge clock);
    if (!rstn) begin
      m_init = 1; m_inflight = 0; m_cycles = 0; m_ir = '0;
      m_step = '0; m_status = '0; m_fault = 0;
    end else if (m_inflight) begin
      m_fault  = 0;
      m_cycles = m_cycles + 1;
      if (cw[2]) m_status = st;
      if (cw[1:0] == 2'b00) begin
        m_inflight = 0;
      end else if (m_cycles >= MAX_STEPS) begin
        m_inflight = 0;
        m_fault    = 1;
      end else begin
        m_step = cw[1:0];
      end
    end else begin
      m_fault = 0;
      if (r && v) begin
        m_ir = ins; m_step = 2'd0; m_cycles = 0; m_inflight = 1;
      end
    end
  endtask

  localparam logic [32:0] ADDI = 33'h1_0000_0204;

  initial begin
    reset_n = 0; run = 0; instr_valid = 0;
    instr_in = '0; status_in = '0; cw_in = '0;

    apply(0, 0, 0, 32'h0, 5'h0, 33'h0);
    apply(0, 1, 1, 32'hFFFF_FFFF, 5'h1F, ADDI);

    // single-cycle ADDI with status load
    apply(1, 1, 1, 32'h0010_0093, 5'b10010, ADDI);
    apply(1, 1, 0, 32'h0, 5'b10010, ADDI);
    apply(1, 0, 0, 32'h0, 5'b00000, 33'h0);

    // three-step instruction
    apply(1, 1, 1, 32'hA5A5_0001, 5'h03, 33'h0);
    apply(1, 1, 0, 32'h0, 5'h04, 33'h0_0000_0001);
    apply(1, 1, 0, 32'h0, 5'h05, 33'h0_0000_0006);
    apply(1, 0, 0, 32'h0, 5'h06, 33'h0_0000_0004);
    apply(1, 0, 0, 32'h0, 5'h07, 33'h0);

    // overrun: NS stuck at 01
    apply(1, 1, 1, 32'hDEAD_BEEF, 5'h00, 33'h0);
    for (int i = 0; i < 5; i++)
      apply(1, 0, 0, 32'h0, 5'h11, 33'h1_0000_0201);
    apply(1, 0, 0, 32'h0, 5'h00, 33'h0);

    // run low ignores instr_valid
    apply(1, 0, 1, 32'h1234_5678, 5'h00, ADDI);
    apply(1, 0, 1, 32'h8765_4321, 5'h00, ADDI);

    // run dropped mid multi-step
    apply(1, 1, 1, 32'hCAFE_0002, 5'h00, 33'h0);
    apply(1, 0, 1, 32'h0, 5'h00, 33'h0_0000_0002);
    apply(1, 0, 1, 32'h0, 5'h00, 33'h0_0000_0000);
    apply(1, 0, 1, 32'h0, 5'h00, 33'h0);

    // reset during second EXEC cycle
    apply(1, 1, 1, 32'hBEEF_0003, 5'h00, 33'h0);
    apply(1, 1, 0, 32'h0, 5'h0A, 33'h0_0000_0005);
    apply(0, 1, 1, 32'h0, 5'h0B, 33'h1_FFFF_FFFF);
    apply(1, 1, 1, 32'h0BAD_F00D, 5'h00, 33'h0);
    apply(1, 1, 0, 32'h0, 5'h00, 33'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [32:0] cw;
      cw = {1'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) cw[1:0] = 2'b00;
      apply($urandom_range(0, 99) > 2, $urandom_range(0, 9) > 1,
            1'($urandom), 32'($urandom), 5'($urandom), cw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Fetch/execute sequencer for the control unit. Holds the instruction register, the 2-bit execute-step state and the status register. It feeds these to the instruction decoders, then takes back the decoder-selected 33-bit control word. The word is gated onto the datapath and its NS field drives multi-cycle instructions. The block sits between instruction memory, the decoder mux and the datapath (ALU, register file, RAM, PC).

## Interface
Parameters:
- `MAX_STEPS`, 4: maximum execute cycles per instruction before a forced return to fetch (legal range 1..4).

Ports:
- `clock`  input  1  single system clock; all state changes on the rising edge.
- `reset_n`  input  1  synchronous, active-low reset.
- `run`  input  1  enables fetching of new instructions.
- `instr_in`  input  32  instruction word from instruction memory.
- `instr_valid`  input  1  instruction memory has `instr_in` valid this cycle.
- `status_in`  input  5  ALU status flags.
- `cw_in`  input  33  control word from the decoder mux, valid combinationally from `ir_q`/`state_q`.
- `fetch_req`  output  1  request an instruction at the current PC.
- `ir_q`  output  32  instruction register, to decoders.
- `state_q`  output  2  execute step presented to decoders.
- `status_q`  output  5  latched status, to branch decoders.
- `cw_out`  output  33  gated control word to the datapath.
- `busy`  output  1  high while in EXEC.
- `seq_fault`  output  1  one-cycle pulse on step-limit overrun.

## Operation
- Control word layout, bit 32 down to 0:
  - alu_en[32], alu_bs[31], alu_fs[30:26], rfb_en[25]
  - sa[24:20], sb[19:15], wa[14:10]
  - reg_w[9], ram_en[8], ram_w[7], pc_en[6], pc_fs[5:4], pc_sel[3]
  - status_load[2], NS[1:0]
- States: FETCH, EXEC.
- FETCH:
  - `fetch_req` = `run`.
  - `cw_out` = all zeros, except pc_fs = 2'b01 in the cycle where `run & instr_valid` (PC increment). Otherwise pc_fs = 2'b00 (hold).
  - On an edge with `run & instr_valid`: `ir_q` <= `instr_in`, `state_q` <= 0, step counter <= 0, go to EXEC.
  - `instr_valid` is ignored when `run` = 0.
- EXEC:
  - `fetch_req` = 0, `busy` = 1, `cw_out` = `cw_in` unmodified.
  - On each edge, if `cw_in[2]` = 1 then `status_q` <= `status_in`.
  - If NS = 2'b00: go to FETCH.
  - Else, if step counter = `MAX_STEPS`-1: go to FETCH and pulse `seq_fault`. The datapath writes of that cycle still occur.
  - Else: `state_q` <= NS, step counter +1, stay in EXEC.
- `run` deasserted during EXEC does not abort: the instruction completes, then the block idles in FETCH.
- Step counter is 2 bits and never wraps, because the limit check precedes the increment.

## Timing
- Reset values (edge with `reset_n` = 0):
  - state FETCH, `ir_q` = 0, `state_q` = 0, `status_q` = 0, step counter = 0.
  - `seq_fault` = 0, `busy` = 0, `fetch_req` = 0 during reset.
- `cw_out` is forced to all zeros while `reset_n` = 0, including mid-EXEC. No register, RAM, PC or status write may be issued in a reset cycle.
- The instruction is latched on the edge where `instr_valid` is seen. The first EXEC cycle follows immediately.
- Single-cycle instruction (NS = 0): 1 accepting FETCH cycle + 1 EXEC cycle. Back-to-back instructions issue every 2 cycles when `instr_valid` is held high.
- `seq_fault` is registered: high for exactly the cycle after the overrun edge.
- `cw_out`, `fetch_req` and `busy` are combinational from registered state plus `cw_in`/`run`/`instr_valid`. There is no extra latency.

## Test plan
- Reset, then `run` = 1, `instr_valid` = 1, and `cw_in` = ADDI word with NS = 00 and bit 2 = 1.
  - Expected: `ir_q` = instruction on the next edge, one EXEC cycle with `cw_out` = `cw_in`, `status_q` = `status_in` (e.g. 5'b10010) after that edge, then back to FETCH.
  - In the fetch-accept cycle, `cw_out` = 33'h0_0000_0010.
- Three-step instruction: decoder returns NS = 01, then 10, then 00.
  - Expected: `state_q` sequence 0, 1, 2, then FETCH. `busy` high for 3 cycles, no fault.
- Overrun: decoder always returns NS = 01 with `MAX_STEPS` = 4.
  - Expected: exactly 4 EXEC cycles, then FETCH, `seq_fault` high for 1 cycle.
- `run` = 0 with `instr_valid` = 1.
  - Expected: `fetch_req` = 0, `ir_q` unchanged, `cw_out` = 0.
  - `run` dropped mid multi-step: the instruction finishes, then the block idles.
- `reset_n` low during the 2nd EXEC cycle of a multi-step instruction.
  - Expected: `cw_out` = 0 in that cycle, all registers at reset values next cycle, fetch resumes when `reset_n` = 1 and `run` = 1.
